// File: rtl/bac_pkg.sv
// Shared definitions for the Bulls-and-Cows digit-entry front end:
// digit/key constants, controller state encoding and the key decoder.
package bac_pkg;

  localparam logic [3:0] EMPTY_DIGIT = 4'hF;
  localparam int         NUM_KEYS    = 10;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    SUBMIT = 2'd1,
    HOLD   = 2'd2,
    LOCKED = 2'd3
  } state_e;

  // Decoded key vector: valid only when exactly one key is set.
  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } key_dec_t;

  // One-hot key vector to BCD digit, with a flag telling whether the
  // vector really was one-hot (zero or several keys give valid=0).
  function automatic key_dec_t onehot_to_bcd(input logic [NUM_KEYS-1:0] vec);
    key_dec_t    res;
    int unsigned ones;
    res.valid = 1'b0;
    res.digit = EMPTY_DIGIT;
    ones      = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (vec[i]) begin
        ones      = ones + 1;
        res.digit = 4'(i);
      end else begin
        ones      = ones;
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioning: 2-flop synchroniser followed by a debouncer that
// only moves its output level after DEBOUNCE_CYC consecutive equal samples.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int             CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Synchroniser chain for the asynchronous raw key level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so only a steady change flips it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/guess_entry_ctrl.sv
// Digit-entry controller: debounces the ten digit keys, collects four
// distinct digits into a BCD guess word, strobes the submission, counts
// attempts and locks the game on a win or when attempts run out.
module guess_entry_ctrl
  import bac_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int MAX_ATTEMPTS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                clr,
  input  logic                result_win,
  output logic [15:0]         guess,
  output logic                guess_valid,
  output logic                dup_err,
  output logic [2:0]          entry_count,
  output logic [3:0]          attempt,
  output logic                win,
  output logic                lose
);

  localparam logic [3:0]  MAX_ATT     = 4'(MAX_ATTEMPTS);
  localparam logic [15:0] EMPTY_GUESS = {4{EMPTY_DIGIT}};

  logic [NUM_KEYS-1:0] db_s;
  key_dec_t            dec_s;
  logic                press_s;
  logic                dup_s;

  state_e      state_q,       state_d;
  logic [15:0] guess_q,       guess_d;
  logic [2:0]  count_q,       count_d;
  logic [3:0]  attempt_q,     attempt_d;
  logic        win_q,         win_d;
  logic        lose_q,        lose_d;
  logic        guess_valid_q, guess_valid_d;
  logic        dup_err_q,     dup_err_d;
  logic        armed_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (key[k]),
      .level_o (db_s[k])
    );
  end

  // Write digit d into slot idx of the guess word (slot 0 is the top nibble).
  function automatic logic [15:0] load_slot(input logic [15:0] g,
                                            input logic [2:0]  idx,
                                            input logic [3:0]  d);
    logic [15:0] r;
    r = g;
    case (idx)
      3'd0:    r[15:12] = d;
      3'd1:    r[11:8]  = d;
      3'd2:    r[7:4]   = d;
      3'd3:    r[3:0]   = d;
      default: r        = g;
    endcase
    return r;
  endfunction

  // Press detection: a one-hot debounced vector seen while the previous
  // cycle was all-zero; further events wait until every key is released.
  always_comb begin
    dec_s   = onehot_to_bcd(db_s);
    press_s = armed_q & dec_s.valid;
  end

  // Duplicate check of the pressed digit against the filled slots only.
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < count_q) && (guess_q[15-4*i -: 4] == dec_s.digit)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
  end

  // Next-state and output logic of the entry FSM; clr beats a key event.
  always_comb begin
    state_d       = state_q;
    guess_d       = guess_q;
    count_d       = count_q;
    attempt_d     = attempt_q;
    win_d         = win_q;
    lose_d        = lose_q;
    guess_valid_d = 1'b0;
    dup_err_d     = 1'b0;
    case (state_q)
      ENTRY: begin
        if (clr) begin
          guess_d = EMPTY_GUESS;
          count_d = 3'd0;
        end else if (press_s) begin
          if (dup_s) begin
            dup_err_d = 1'b1;
          end else begin
            guess_d = load_slot(guess_q, count_q, dec_s.digit);
            count_d = count_q + 3'd1;
            if (count_q == 3'd3) begin
              state_d       = SUBMIT;
              guess_valid_d = 1'b1;
              attempt_d     = (attempt_q < MAX_ATT) ? attempt_q + 4'd1 : attempt_q;
            end else begin
              state_d = ENTRY;
            end
          end
        end else begin
          state_d = ENTRY;
        end
      end
      SUBMIT: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (clr) begin
          guess_d = EMPTY_GUESS;
          count_d = 3'd0;
          state_d = ENTRY;
        end else if (result_win) begin
          win_d   = 1'b1;
          state_d = LOCKED;
        end else if (attempt_q == MAX_ATT) begin
          lose_d  = 1'b1;
          state_d = LOCKED;
        end else if (press_s) begin
          guess_d = {dec_s.digit, EMPTY_DIGIT, EMPTY_DIGIT, EMPTY_DIGIT};
          count_d = 3'd1;
          state_d = ENTRY;
        end else begin
          state_d = HOLD;
        end
      end
      LOCKED: begin
        if (clr) begin
          guess_d   = EMPTY_GUESS;
          count_d   = 3'd0;
          attempt_d = 4'd0;
          win_d     = 1'b0;
          lose_d    = 1'b0;
          state_d   = ENTRY;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ENTRY;
      guess_q       <= EMPTY_GUESS;
      count_q       <= 3'd0;
      attempt_q     <= 4'd0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      guess_valid_q <= 1'b0;
      dup_err_q     <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      guess_q       <= guess_d;
      count_q       <= count_d;
      attempt_q     <= attempt_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      guess_valid_q <= guess_valid_d;
      dup_err_q     <= dup_err_d;
      armed_q       <= (db_s == '0);
    end
  end

  assign guess       = guess_q;
  assign guess_valid = guess_valid_q;
  assign dup_err     = dup_err_q;
  assign entry_count = count_q;
  assign attempt     = attempt_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl with a scoreboard: expected submit and
// duplicate strobes are queued by the stimulus and checked by a monitor.
module tb_guess_entry_ctrl;

  localparam int DB  = 4;
  localparam int MAX = 3;

  typedef struct {
    logic [15:0] guess;
    logic [3:0]  attempt;
  } sub_exp_t;

  typedef struct {
    logic [15:0] guess;
    logic [2:0]  count;
  } dup_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  key;
  logic        clr;
  logic        result_win;
  logic [15:0] guess;
  logic        guess_valid;
  logic        dup_err;
  logic [2:0]  entry_count;
  logic [3:0]  attempt;
  logic        win;
  logic        lose;

  int n_pass  = 0;
  int n_total = 0;

  sub_exp_t sub_q[$];
  dup_exp_t dup_q[$];

  guess_entry_ctrl #(.DEBOUNCE_CYC(DB), .MAX_ATTEMPTS(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .clr         (clr),
    .result_win  (result_win),
    .guess       (guess),
    .guess_valid (guess_valid),
    .dup_err     (dup_err),
    .entry_count (entry_count),
    .attempt     (attempt),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every strobe from the DUT must match the next queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (guess_valid === 1'b1) begin
        if (sub_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_guess_valid: guess %0h attempt %0d, none expected", guess, attempt);
        end else begin
          sub_exp_t e;
          e = sub_q.pop_front();
          chk("submit_guess",   32'(guess),       32'(e.guess));
          chk("submit_attempt", 32'(attempt),     32'(e.attempt));
          chk("submit_count",   32'(entry_count), 32'd4);
        end
      end
      if (dup_err === 1'b1) begin
        if (dup_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_dup_err: guess %0h count %0d, none expected", guess, entry_count);
        end else begin
          dup_exp_t d;
          d = dup_q.pop_front();
          chk("dup_guess", 32'(guess),       32'(d.guess));
          chk("dup_count", 32'(entry_count), 32'(d.count));
        end
      end
    end
  end

  task automatic press(input int d);
    @(negedge clk);
    key[d] = 1'b1;
    repeat (DB + 4) @(negedge clk);
    key[d] = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic [15:0] g, input logic [2:0] c,
                           input logic [3:0] a, input logic w, input logic l);
    chk({name, "_guess"},   32'(guess),       32'(g));
    chk({name, "_count"},   32'(entry_count), 32'(c));
    chk({name, "_attempt"}, 32'(attempt),     32'(a));
    chk({name, "_win"},     32'(win),         32'(w));
    chk({name, "_lose"},    32'(lose),        32'(l));
  endtask

  initial begin
    rst        = 1'b0;
    key        = 10'd0;
    clr        = 1'b0;
    result_win = 1'b0;
    repeat (3) @(negedge clk);
    chk_state("reset", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);
    chk("reset_gv",  32'(guess_valid), 32'd0);
    chk("reset_dup", 32'(dup_err),     32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // First game: 1234, then a win locks the guess.
    press(1);
    chk("step1_count", 32'(entry_count), 32'd1);
    press(2);
    chk("step2_count", 32'(entry_count), 32'd2);
    press(3);
    chk("step3_count", 32'(entry_count), 32'd3);
    sub_q.push_back('{16'h1234, 4'd1});
    press(4);
    chk_state("hold1", 16'h1234, 3'd4, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    result_win = 1'b1;
    @(negedge clk);
    result_win = 1'b0;
    chk_state("win", 16'h1234, 3'd4, 4'd1, 1'b1, 1'b0);
    press(5);
    chk_state("locked_key", 16'h1234, 3'd4, 4'd1, 1'b1, 1'b0);
    clr_pulse();
    chk_state("restart", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);

    // Duplicate digit.
    press(5);
    dup_q.push_back('{16'h5FFF, 3'd1});
    press(5);
    press(6);
    chk_state("dup", 16'h56FF, 3'd2, 4'd0, 1'b0, 1'b0);
    clr_pulse();
    chk_state("clr_entry", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);

    // Short glitch on key 7 must not register.
    @(negedge clk);
    key[7] = 1'b1;
    repeat (3) @(negedge clk);
    key[7] = 1'b0;
    repeat (DB + 6) @(negedge clk);
    chk_state("glitch", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);

    // Two keys together are ignored; a later single press counts.
    @(negedge clk);
    key[2] = 1'b1;
    key[3] = 1'b1;
    repeat (DB + 4) @(negedge clk);
    key[2] = 1'b0;
    key[3] = 1'b0;
    repeat (DB + 4) @(negedge clk);
    chk("multi_count", 32'(entry_count), 32'd0);
    press(8);
    chk_state("multi_then8", 16'h8FFF, 3'd1, 4'd0, 1'b0, 1'b0);
    clr_pulse();

    // Three wrong guesses exhaust the attempts.
    sub_q.push_back('{16'h1234, 4'd1});
    press(1); press(2); press(3); press(4);
    chk_state("wrong1", 16'h1234, 3'd4, 4'd1, 1'b0, 1'b0);
    press(5);
    chk_state("hold_restart", 16'h5FFF, 3'd1, 4'd1, 1'b0, 1'b0);
    sub_q.push_back('{16'h5678, 4'd2});
    press(6); press(7); press(8);
    chk_state("wrong2", 16'h5678, 3'd4, 4'd2, 1'b0, 1'b0);
    sub_q.push_back('{16'h9012, 4'd3});
    press(9); press(0); press(1); press(2);
    chk_state("lose", 16'h9012, 3'd4, 4'd3, 1'b0, 1'b1);
    clr_pulse();
    chk_state("clr_lose", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);

    // clr in the same cycle as the press event of 9.
    press(4);
    press(7);
    chk_state("pre_clr", 16'h47FF, 3'd2, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    key[9] = 1'b1;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_state("clr_vs_key", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);
    key[9] = 1'b0;
    repeat (DB + 4) @(negedge clk);
    chk_state("clr_vs_key_late", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);

    // Reset mid-entry with key 1 held.
    press(4); press(5); press(6);
    chk("pre_rst_count", 32'(entry_count), 32'd3);
    @(negedge clk);
    key[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_state("rst_mid", 16'hFFFF, 3'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (DB + 2) @(posedge clk);
    #1;
    chk("rst_held_early", 32'(entry_count), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held_count", 32'(entry_count), 32'd1);
    chk("rst_held_guess", 32'(guess),       32'h1FFF);
    @(negedge clk);
    key[1] = 1'b0;
    repeat (DB + 4) @(negedge clk);

    chk("sub_queue_empty", 32'(sub_q.size()), 32'd0);
    chk("dup_queue_empty", 32'(dup_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
